// File: rtl/vrf_wr_arbiter.sv
// vrf_wr_arbiter: shares the single VRF write port between REQ_NUM writeback
// requesters. A round-robin winner gets one START cycle (VRF write-FSM start)
// followed by a burst of LANES elements; valid-low cycles stall the burst.
// busy_reg_o flags the destination register so reads can stall on RAW hazards.
//
// Build option: define VRF_WARB_MASK_PRIO_EN so that requests targeting the mask
// register v0 win over plain round-robin.
//
// state | meaning
// IDLE  | no burst; arbitrate among req_valid_i, latch winner and address
// START | vrf_wr_req_o for one cycle so the VRF write FSM reaches its enable state
// BURST | stream elements from the winner; finishes on the LANES-th accepted element
module vrf_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4,
  parameter int REQ_NUM    = 3,
  localparam int ADDR_B    = $clog2(REG_NUM),
  localparam int ELEM_B    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int REQ_B     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [REQ_NUM-1:0]            req_valid_i,
  input  logic [REQ_NUM*ADDR_B-1:0]     req_addr_i,
  output logic [REQ_NUM-1:0]            req_grant_o,
  input  logic [REQ_NUM-1:0]            elem_valid_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] elem_data_i,
  output logic [REQ_NUM-1:0]            elem_ready_o,
  output logic [REQ_NUM-1:0]            done_o,
  output logic                          vrf_wr_req_o,
  output logic                          vrf_wr_en_o,
  output logic                          vrf_wr_ready_o,
  output logic [ADDR_B-1:0]             vrf_wr_addr_o,
  output logic [ELEM_B-1:0]             vrf_wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0]         vrf_wdata_o,
  output logic                          busy_o,
  output logic [REG_NUM-1:0]            busy_reg_o
);

  typedef enum logic [1:0] {IDLE, START, BURST} state_t;

  state_t              state;
  logic [REQ_B-1:0]    rr_ptr;
  logic [REQ_B-1:0]    gnt_idx;
  logic [ADDR_B-1:0]   wr_addr;
  logic [ELEM_B-1:0]   elem_cnt;

  logic                arb_found;
  logic [REQ_B-1:0]    arb_idx;
  logic [ADDR_B-1:0]   arb_addr;
  logic [REQ_B-1:0]    scan;
  int                  scan_i;

  logic [ADDR_B-1:0]     req_addr_a  [REQ_NUM];
  logic [DATA_WIDTH-1:0] elem_data_a [REQ_NUM];
  logic [REQ_NUM-1:0]    gnt_oh;
  logic                  active;
  logic                  bursting;
  logic                  accept;
  logic                  last_elem;

  for (genvar r = 0; r < REQ_NUM; r++) begin : g_unpack
    assign req_addr_a[r]  = req_addr_i[r*ADDR_B +: ADDR_B];
    assign elem_data_a[r] = elem_data_i[r*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pick the first requesting slot at or after rr_ptr (with wrap); optional v0 priority pass first
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = '0;
    scan_i    = 0;
`ifdef VRF_WARB_MASK_PRIO_EN
    for (int i = 0; i < REQ_NUM; i++) begin
      scan_i = int'(rr_ptr) + i;
      if (scan_i >= REQ_NUM) scan_i = scan_i - REQ_NUM;
      scan = REQ_B'(scan_i);
      if (!arb_found && req_valid_i[scan] && (req_addr_a[scan] == '0)) begin
        arb_found = 1'b1;
        arb_idx   = scan;
      end
    end
`endif
    for (int i = 0; i < REQ_NUM; i++) begin
      scan_i = int'(rr_ptr) + i;
      if (scan_i >= REQ_NUM) scan_i = scan_i - REQ_NUM;
      scan = REQ_B'(scan_i);
      if (!arb_found && req_valid_i[scan]) begin
        arb_found = 1'b1;
        arb_idx   = scan;
      end
    end
    arb_addr = req_addr_a[arb_idx];
  end

  // Burst sequencing: arbitration, one START cycle, element counting through BURST
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      wr_addr  <= '0;
      elem_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            gnt_idx <= arb_idx;
            wr_addr <= arb_addr;
            rr_ptr  <= (arb_idx == REQ_B'(REQ_NUM-1)) ? '0 : arb_idx + 1'b1;
            state   <= START;
          end
        end
        START: begin
          elem_cnt <= '0;
          state    <= BURST;
        end
        BURST: begin
          if (accept) begin
            if (last_elem) begin
              elem_cnt <= '0;
              state    <= IDLE;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-hot of the held grant index
  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = 1'b1;
  end

  // Mark the destination register while a burst owns the port
  always_comb begin
    busy_reg_o = '0;
    if (active) busy_reg_o[wr_addr] = 1'b1;
  end

  assign active    = (state != IDLE);
  assign bursting  = (state == BURST);
  assign accept    = bursting && elem_valid_i[gnt_idx];
  assign last_elem = accept && (elem_cnt == ELEM_B'(LANES-1));

  assign req_grant_o       = active   ? gnt_oh : '0;
  assign elem_ready_o      = bursting ? gnt_oh : '0;
  assign done_o            = last_elem ? gnt_oh : '0;
  assign vrf_wr_req_o      = (state == START);
  assign vrf_wr_en_o       = accept;
  assign vrf_wr_ready_o    = last_elem;
  assign vrf_wr_addr_o     = active ? wr_addr : '0;
  assign vrf_wr_elem_cnt_o = active ? elem_cnt : '0;
  assign vrf_wdata_o       = bursting ? elem_data_a[gnt_idx] : '0;
  assign busy_o            = active;

endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// Testbench for vrf_wr_arbiter: requester agents issue bursts, a scoreboard
// holds the expected element writes per requester, and a negedge monitor
// checks arbitration order and every write against the reference model.
`timescale 1ns/1ps
module tb_vrf_wr_arbiter;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [2:0]   req_valid_i;
  logic [14:0]  req_addr_i;
  logic [2:0]   req_grant_o;
  logic [2:0]   elem_valid_i;
  logic [95:0]  elem_data_i;
  logic [2:0]   elem_ready_o;
  logic [2:0]   done_o;
  logic         vrf_wr_req_o;
  logic         vrf_wr_en_o;
  logic         vrf_wr_ready_o;
  logic [4:0]   vrf_wr_addr_o;
  logic [1:0]   vrf_wr_elem_cnt_o;
  logic [31:0]  vrf_wdata_o;
  logic         busy_o;
  logic [31:0]  busy_reg_o;

  logic [4:0]   addr_a [3];
  logic [31:0]  data_a [3];

  assign req_addr_i  = {addr_a[2], addr_a[1], addr_a[0]};
  assign elem_data_i = {data_a[2], data_a[1], data_a[0]};

  always #5 clk_i = ~clk_i;

  vrf_wr_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_grant_o(req_grant_o),
    .elem_valid_i(elem_valid_i), .elem_data_i(elem_data_i), .elem_ready_o(elem_ready_o),
    .done_o(done_o), .vrf_wr_req_o(vrf_wr_req_o), .vrf_wr_en_o(vrf_wr_en_o),
    .vrf_wr_ready_o(vrf_wr_ready_o), .vrf_wr_addr_o(vrf_wr_addr_o),
    .vrf_wr_elem_cnt_o(vrf_wr_elem_cnt_o), .vrf_wdata_o(vrf_wdata_o),
    .busy_o(busy_o), .busy_reg_o(busy_reg_o)
  );

  typedef struct packed { logic [4:0] addr; logic [3:0][31:0] data; } burst_t;
  typedef struct packed { logic [4:0] addr; logic [1:0] cnt; logic [31:0] data; } exp_t;

  burst_t     bq [3][$];
  exp_t       exp_q [3][$];
  int         ag_k [3];
  int         stall_pct [3];
  int         stall_at [3];
  int         stall_left [3];
  bit         extra_req [3];
  logic [4:0] extra_addr [3];
  bit         noise_en;

  int         n_checks = 0;
  int         n_err = 0;

  int         mdl_ptr;
  bit         exp_start;
  bit         in_burst;
  logic [1:0] exp_win;
  logic [1:0] owner;
  logic [4:0] exp_addr;
  logic [2:0] grant_log [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [2:0] oh(input logic [1:0] i);
    logic [2:0] v;
    v = 3'b001 << i;
    return v;
  endfunction

  task automatic add_burst(input logic [1:0] r, input logic [4:0] a,
                           input logic [31:0] base, input bit seq);
    burst_t b;
    exp_t   e;
    logic [1:0] k2;
    b.addr = a;
    for (int k = 0; k < 4; k++) begin
      k2 = k[1:0];
      b.data[k2] = seq ? base + 32'(k) : $urandom;
    end
    bq[r].push_back(b);
    for (int k = 0; k < 4; k++) begin
      k2 = k[1:0];
      e.addr = a; e.cnt = k2; e.data = b.data[k2];
      exp_q[r].push_back(e);
    end
  endtask

  task automatic drive();
    logic [1:0] r;
    for (int i = 0; i < 3; i++) begin
      r = i[1:0];
      if (bq[r].size() > 0) begin
        req_valid_i[r] = 1'b1;
        addr_a[r]      = bq[r][0].addr;
      end else begin
        req_valid_i[r] = extra_req[r];
        addr_a[r]      = extra_addr[r];
      end
      if (req_grant_o[r] && bq[r].size() > 0) begin
        if (stall_left[r] > 0 && ag_k[r] == stall_at[r]) begin
          elem_valid_i[r] = 1'b0;
          stall_left[r]--;
        end else begin
          elem_valid_i[r] = ($urandom_range(99) >= 32'(stall_pct[r]));
        end
        data_a[r] = bq[r][0].data[ag_k[r][1:0]];
      end else begin
        elem_valid_i[r] = noise_en ? 1'($urandom_range(1)) : 1'b0;
        data_a[r]       = $urandom;
      end
    end
  endtask

  task automatic agent_update();
    logic [1:0] r;
    for (int i = 0; i < 3; i++) begin
      r = i[1:0];
      if (elem_ready_o[r] && elem_valid_i[r] && bq[r].size() > 0) begin
        ag_k[r]++;
        if (ag_k[r] == 4) begin
          void'(bq[r].pop_front());
          ag_k[r] = 0;
        end
      end
    end
  endtask

  // one clock: agents observe acceptance at negedge, new stimulus #1 after posedge
  task automatic step();
    @(negedge clk_i);
    agent_update();
    @(posedge clk_i);
    #1;
    drive();
  endtask

  function automatic bit drained();
    return (bq[0].size() == 0) && (bq[1].size() == 0) && (bq[2].size() == 0) &&
           !exp_start && !in_burst && !busy_o;
  endfunction

  task automatic wait_drain(input int maxc, input string nm);
    int c;
    c = 0;
    while (!drained() && c < maxc) begin
      step();
      c++;
    end
    n_checks++;
    if (!drained()) begin
      n_err++;
      $display("FAIL %s: not drained after %0d cycles, expected idle", nm, c);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [2:0] expv);
    if (idx < grant_log.size()) chk(nm, 128'(grant_log[idx]), 128'(expv));
    else begin
      n_checks++;
      n_err++;
      $display("FAIL %s: grant %0d never seen, expected %0h", nm, idx, expv);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < 3; i++) begin
      bq[i].delete();
      exp_q[i].delete();
      ag_k[i] = 0; stall_left[i] = 0; stall_at[i] = 0;
      extra_req[i] = 1'b0; extra_addr[i] = '0;
    end
    mdl_ptr = 0; exp_start = 1'b0; in_burst = 1'b0;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({req_grant_o, elem_ready_o, done_o, vrf_wr_req_o, vrf_wr_en_o,
                 vrf_wr_ready_o, vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o,
                 busy_o, busy_reg_o});
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    flush_model();
    step();
    step();
    chk("reset_outputs", all_outs(), '0);
    reset_i = 1'b0;
  endtask

  // Reference model and scoreboard: arbitration by spec rules, writes popped from per-requester queues
  always @(negedge clk_i) begin : mon
    exp_t e;
    int   best, key, bestkey;
    bit   last;
    if (!reset_i) begin
      if (exp_start) begin
        chk("start_req", 128'(vrf_wr_req_o), 128'(1'b1));
        chk("start_grant", 128'(req_grant_o), 128'(oh(exp_win)));
        chk("start_addr", 128'(vrf_wr_addr_o), 128'(exp_addr));
        chk("start_cnt", 128'(vrf_wr_elem_cnt_o), '0);
        chk("start_busy_reg", 128'(busy_reg_o), 128'(32'(1) << exp_addr));
        chk("start_no_en", 128'({vrf_wr_en_o, elem_ready_o, done_o}), '0);
        grant_log.push_back(req_grant_o);
        owner     = exp_win;
        in_burst  = 1'b1;
        exp_start = 1'b0;
      end else if (in_burst) begin
        chk("burst_req_low", 128'(vrf_wr_req_o), '0);
        chk("burst_grant", 128'(req_grant_o), 128'(oh(owner)));
        chk("burst_ready", 128'(elem_ready_o), 128'(oh(owner)));
        chk("burst_en", 128'(vrf_wr_en_o), 128'(elem_valid_i[owner]));
        chk("burst_busy", 128'(busy_o), 128'(1'b1));
        if (exp_q[owner].size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL burst_scoreboard: requester %0d has no expected element", owner);
          in_burst = 1'b0;
        end else begin
          e = exp_q[owner][0];
          chk("burst_addr", 128'(vrf_wr_addr_o), 128'(e.addr));
          chk("burst_cnt", 128'(vrf_wr_elem_cnt_o), 128'(e.cnt));
          chk("burst_busy_reg", 128'(busy_reg_o), 128'(32'(1) << e.addr));
          if (vrf_wr_en_o) begin
            void'(exp_q[owner].pop_front());
            last = (e.cnt == 2'd3);
            chk("wr_data", 128'(vrf_wdata_o), 128'(e.data));
            chk("wr_ready", 128'(vrf_wr_ready_o), 128'(last));
            chk("wr_done", 128'(done_o), last ? 128'(oh(owner)) : '0);
            if (last) in_burst = 1'b0;
          end else begin
            chk("stall_no_done", 128'({vrf_wr_ready_o, done_o}), '0);
          end
        end
      end else begin
        chk("idle_outputs", all_outs(), '0);
        best = -1;
        bestkey = 99;
        for (int i = 0; i < 3; i++) begin
          if (req_valid_i[i[1:0]]) begin
            key = (i - mdl_ptr + 3) % 3;
`ifdef VRF_WARB_MASK_PRIO_EN
            if (addr_a[i[1:0]] != 5'd0) key = key + 3;
`endif
            if (key < bestkey) begin
              bestkey = key;
              best = i;
            end
          end
        end
        if (best >= 0) begin
          exp_start = 1'b1;
          exp_win   = best[1:0];
          exp_addr  = addr_a[best[1:0]];
          mdl_ptr   = (best + 1) % 3;
        end
      end
    end
  end

  initial begin
    int base, pushed, c;
    logic [1:0] rr;
    logic [4:0] ra;
    reset_i = 1'b1;
    req_valid_i = '0;
    elem_valid_i = '0;
    noise_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = '0; data_a[i] = '0; stall_pct[i] = 0;
    end
    flush_model();
    do_reset();

    // single request: addr 5, data A0..A3
    add_burst(2'd0, 5'd5, 32'hA0, 1'b1);
    wait_drain(100, "single_drain");

    // round-robin with all three held continuously
    do_reset();
    base = grant_log.size();
    for (int i = 0; i < 3; i++) begin
      add_burst(i[1:0], 5'(10 + i), 32'(16 * i), 1'b1);
      add_burst(i[1:0], 5'(20 + i), 32'(256 + 16 * i), 1'b1);
    end
    wait_drain(200, "rr_drain");
    chk_log("rr_grant0", base + 0, 3'b001);
    chk_log("rr_grant1", base + 1, 3'b010);
    chk_log("rr_grant2", base + 2, 3'b100);
    chk_log("rr_grant3", base + 3, 3'b001);

    // stall: requester 1 drops valid for 3 cycles after element 1
    stall_at[1] = 2;
    stall_left[1] = 3;
    add_burst(2'd1, 5'd9, 32'hB0, 1'b1);
    wait_drain(100, "stall_drain");

    // withdraw and ignore: noise on non-granted valids, one-cycle request from 2
    base = grant_log.size();
    noise_en = 1'b1;
    stall_pct[1] = 50;
    add_burst(2'd1, 5'd3, 32'hC0, 1'b1);
    c = 0;
    while (!busy_o && c < 20) begin step(); c++; end
    chk("withdraw_busy_seen", 128'(busy_o), 128'(1'b1));
    extra_req[2] = 1'b1;
    extra_addr[2] = 5'd4;
    step();
    extra_req[2] = 1'b0;
    wait_drain(200, "withdraw_drain");
    chk("withdraw_grant_cnt", 128'(grant_log.size() - base), 128'(1));
    chk_log("withdraw_grant", base, 3'b010);
    noise_en = 1'b0;
    stall_pct[1] = 0;

    // reset mid-burst at element 2, then rr restarts from requester 0
    add_burst(2'd0, 5'd12, 32'hD0, 1'b1);
    c = 0;
    while (!(busy_o && vrf_wr_elem_cnt_o == 2'd2) && c < 40) begin step(); c++; end
    chk("midburst_cnt2_seen", 128'(vrf_wr_elem_cnt_o), 128'(2'd2));
    reset_i = 1'b1;
    #1;
    chk("midburst_reset_outs", all_outs(), '0);
    chk("midburst_no_done", 128'(done_o), '0);
    do_reset();
    base = grant_log.size();
    for (int i = 0; i < 3; i++) add_burst(i[1:0], 5'(i + 1), $urandom, 1'b0);
    wait_drain(200, "postreset_drain");
    chk_log("postreset_first", base, 3'b001);

    // randomized traffic with stalls and noise
    noise_en = 1'b1;
    for (int i = 0; i < 3; i++) stall_pct[i] = 25;
    pushed = 0;
    c = 0;
    while ((pushed < 15 || !drained()) && c < 5000) begin
      if (pushed < 15 && $urandom_range(7) == 0) begin
        rr = 2'($urandom_range(2));
        ra = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
        add_burst(rr, ra, $urandom, 1'b0);
        pushed++;
      end
      step();
      c++;
    end
    n_checks++;
    if (!(pushed == 15 && drained())) begin
      n_err++;
      $display("FAIL random_drain: pushed %0d, drained %0d, expected 15 and 1", pushed, drained());
    end
    chk("random_sb_empty", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), '0);
    noise_en = 1'b0;
    for (int i = 0; i < 3; i++) stall_pct[i] = 0;

    // v0 priority: req 0 addr 7 vs req 2 addr 0 with rr_ptr at 0
    do_reset();
    base = grant_log.size();
    add_burst(2'd0, 5'd7, 32'hE0, 1'b1);
    add_burst(2'd2, 5'd0, 32'hF0, 1'b1);
    wait_drain(100, "prio_drain");
`ifdef VRF_WARB_MASK_PRIO_EN
    chk_log("prio_first", base, 3'b100);
`else
    chk_log("prio_first", base, 3'b001);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
